branch_sequencer: RTL

// Multi-cycle control-transfer sequencer for the RV32I von Neumann core.
// On a start from the control unit it drives the shared branch_predicates

---
 rtl/branch_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/branch_sequencer.sv
// branch_sequencer: multi-cycle branch/JAL/JALR sequencer driving a shared comparator, with event counters
module branch_sequencer #(
    parameter int IALIGN = 32,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       kind,
    input  logic [2:0]       funct3,
    input  logic [31:0]      pc,
    input  logic [31:0]      rs1_val,
    input  logic [31:0]      rs2_val,
    input  logic [31:0]      imm,
    output logic             br_execute,
    output logic [31:0]      cmp_op_a,
    output logic [31:0]      cmp_op_b,
    output logic [2:0]       cmp_funct3,
    input  logic             do_branch,
    output logic             busy,
    output logic             done,
    output logic             taken,
    output logic [31:0]      next_pc,
    output logic [31:0]      link_value,
    output logic             link_we,
    output logic             misaligned,
    output logic             illegal,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);
    localparam logic [1:0] IDLE = 2'd0, CMP = 2'd1, TGT = 2'd2, RESP = 2'd3;

    logic [1:0]  state;
    logic [1:0]  kind_q;
    logic [31:0] pc_q, imm_q;
    logic        br_q;
    logic [31:0] target, pc_plus4;
    logic        raw_taken, mis;

    always_comb begin
        target    = kind_q == 2'b10 ? (cmp_op_a + imm_q) & ~32'd1 : pc_q + imm_q;
        pc_plus4  = pc_q + 32'd4;
        raw_taken = kind_q == 2'b00 ? br_q : 1'b1;
        mis       = raw_taken & (IALIGN == 32 ? |target[1:0] : target[0]);
    end

    assign br_execute = state == CMP;
    assign busy       = state != IDLE;
    assign done       = state == RESP;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            kind_q     <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            br_q       <= 1'b0;
            cmp_op_a   <= '0;
            cmp_op_b   <= '0;
            cmp_funct3 <= '0;
            taken      <= 1'b0;
            next_pc    <= '0;
            link_value <= '0;
            link_we    <= 1'b0;
            misaligned <= 1'b0;
            illegal    <= 1'b0;
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    kind_q     <= kind;
                    cmp_funct3 <= funct3;
                    pc_q       <= pc;
                    cmp_op_a   <= rs1_val;
                    cmp_op_b   <= rs2_val;
                    imm_q      <= imm;
                    taken      <= 1'b0;
                    misaligned <= 1'b0;
                    link_we    <= 1'b0;
                    illegal    <= kind == 2'b11;
                    // Illegal skips straight to RESP, so its results are set here
                    if (kind == 2'b11) begin
                        next_pc    <= pc;
                        link_value <= pc + 32'd4;
                    end
                    state <= kind == 2'b00 ? CMP : kind == 2'b11 ? RESP : TGT;
                end
                CMP: begin
                    br_q  <= do_branch;
                    state <= TGT;
                end
                TGT: begin
                    taken      <= raw_taken & ~mis;
                    misaligned <= mis;
                    next_pc    <= mis ? pc_q : raw_taken ? target : pc_plus4;
                    link_value <= pc_plus4;
                    link_we    <= kind_q != 2'b00 && !mis;
                    state      <= RESP;
                end
                default: begin
                    if (kind_q == 2'b00) begin
                        if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
                        if (taken && taken_cnt != '1) taken_cnt <= taken_cnt + CNT_W'(1);
                    end
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
